// File: rtl/pmem_write_buffer.sv
// rtl/pmem_write_buffer.sv - posted line write buffer between the L2 port and physical memory
// Coalesces writes per line, serves read hits from the FIFO and drains to memory when idle.
module pmem_write_buffer #(
  parameter int DEPTH       = 4,
  parameter int LOG_DEPTH   = 2,
  parameter int LINE_SIZE   = 256,
  parameter int OFFSET_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          mem_address,
  input  logic [LINE_SIZE-1:0] mem_wdata,
  output logic [LINE_SIZE-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [15:0]          pmem_address,
  output logic [LINE_SIZE-1:0] pmem_wdata,
  input  logic [LINE_SIZE-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int TAG_W = 16 - OFFSET_BITS;

  typedef enum logic [1:0] {IDLE, RESP, RD_MEM, DRAIN} state_t;

  state_t               state, state_next;
  logic [DEPTH-1:0]     valid;
  logic [TAG_W-1:0]     tags  [DEPTH];
  logic [LINE_SIZE-1:0] lines [DEPTH];
  logic [LOG_DEPTH-1:0] head, tail, hit_idx;
  logic [LOG_DEPTH:0]   count;
  logic [TAG_W-1:0]     req_tag, rd_tag;
  logic                 hit, full;
  logic                 wr_hit, wr_new, rd_hit, rd_miss, rd_done, drain_done;
  logic                 unused_offset;

  assign req_tag       = mem_address[15:OFFSET_BITS];
  assign unused_offset = ^mem_address[OFFSET_BITS-1:0];
  assign full          = (count == (LOG_DEPTH+1)'(DEPTH));

  // Coalescing keeps tags unique, so at most one entry can hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = LOG_DEPTH'(i);
      end
    end
  end

  always_comb begin
    state_next = state;
    wr_hit     = 1'b0;
    wr_new     = 1'b0;
    rd_hit     = 1'b0;
    rd_miss    = 1'b0;
    rd_done    = 1'b0;
    drain_done = 1'b0;
    case (state)
      IDLE: begin
        if (mem_write) begin
          if (hit) begin
            wr_hit     = 1'b1;
            state_next = RESP;
          end else if (!full) begin
            wr_new     = 1'b1;
            state_next = RESP;
          end else begin
            state_next = DRAIN;
          end
        end else if (mem_read) begin
          if (hit) begin
            rd_hit     = 1'b1;
            state_next = RESP;
          end else begin
            rd_miss    = 1'b1;
            state_next = RD_MEM;
          end
        end else if (count != '0) begin
          state_next = DRAIN;
        end
      end
      RESP: state_next = IDLE;
      RD_MEM: begin
        if (pmem_resp) begin
          rd_done    = 1'b1;
          state_next = RESP;
        end
      end
      DRAIN: begin
        if (pmem_resp) begin
          drain_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus strobes decode straight from state so reset drops them immediately.
  assign mem_resp   = (state == RESP);
  assign pmem_read  = (state == RD_MEM);
  assign pmem_write = (state == DRAIN);
  assign pmem_wdata = (state == DRAIN) ? lines[head] : '0;

  always_comb begin
    pmem_address = '0;
    if (state == RD_MEM) pmem_address = {rd_tag, OFFSET_BITS'(0)};
    else if (state == DRAIN) pmem_address = {tags[head], OFFSET_BITS'(0)};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      valid     <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      mem_rdata <= '0;
      rd_tag    <= '0;
    end else begin
      state <= state_next;
      if (wr_new) begin
        valid[tail] <= 1'b1;
        tail        <= tail + LOG_DEPTH'(1);
        count       <= count + (LOG_DEPTH+1)'(1);
      end
      if (drain_done) begin
        valid[head] <= 1'b0;
        head        <= head + LOG_DEPTH'(1);
        count       <= count - (LOG_DEPTH+1)'(1);
      end
      if (rd_hit)  mem_rdata <= lines[hit_idx];
      if (rd_miss) rd_tag    <= req_tag;
      if (rd_done) mem_rdata <= pmem_rdata;
    end
  end

  // Payload storage needs no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (wr_new) begin
      tags[tail]  <= req_tag;
      lines[tail] <= mem_wdata;
    end
    if (wr_hit) lines[hit_idx] <= mem_wdata;
  end

endmodule

// File: doc/pmem_write_buffer.md
Name: pmem_write_buffer

Overview:
- Posted write buffer between the core's 256-bit physical-memory port (L2 writeback/prefetch side) and physical memory.
- Absorbs dirty-line writebacks into a small FIFO so reads that follow are not serialized behind them.
- Serves read hits from buffered lines, coalesces writes to the same line, and drains to memory when the bus is otherwise idle.

Parameters:
DEPTH, 4, number of buffered lines (power of two, >=2)
LOG_DEPTH, 2, log2(DEPTH)
LINE_SIZE, 256, bits per line
OFFSET_BITS, 5, byte-offset bits ignored for line match

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
mem_read  in  1  upstream read request, held until mem_resp
mem_write  in  1  upstream write request, held until mem_resp
mem_address  in  16  upstream byte address
mem_wdata  in  LINE_SIZE  upstream write line
mem_rdata  out  LINE_SIZE  read data, valid when mem_resp=1
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  physical read request
pmem_write  out  1  physical write request
pmem_address  out  16  physical address, low OFFSET_BITS forced 0
pmem_wdata  out  LINE_SIZE  physical write data
pmem_rdata  in  LINE_SIZE  physical read data
pmem_resp  in  1  physical completion pulse

Behaviour:
- Line tag = address[15:OFFSET_BITS]; entry = {valid, tag, data}; FIFO via head/tail pointers (LOG_DEPTH bits, wrap modulo DEPTH) plus count (LOG_DEPTH+1 bits).
- Reset (async, reset=0): all valid cleared, head=tail=count=0, state=IDLE, all outputs 0. Reset mid-transaction abandons the pmem access; buffered data is discarded.
- States: IDLE, RESP, RD_MEM, DRAIN.
- IDLE priority, evaluated each cycle:
  (1) mem_write and mem_read both high: treated as write.
  (2) mem_write with tag match: overwrite that entry's data -> RESP. No count change.
  (3) mem_write, no match, count<DEPTH: write at tail, tail++, count++ -> RESP.
  (4) mem_write, no match, full: -> DRAIN. The write stays pending and is retried in IDLE afterwards.
  (5) mem_read with tag match: mem_rdata=entry data -> RESP. Latency 1 cycle.
  (6) mem_read, miss: -> RD_MEM.
  (7) No request, count>0: -> DRAIN.
  (8) Otherwise stay in IDLE.
- RESP: mem_resp=1 for exactly one cycle; no request is sampled; -> IDLE. This prevents double-accepting a held request.
- RD_MEM: pmem_read=1, pmem_address={tag,0} held. On pmem_resp, capture pmem_rdata into mem_rdata -> RESP. Total latency = pmem latency + 1.
- DRAIN: pmem_write=1, pmem_address/pmem_wdata from the head entry, held steady. On pmem_resp: clear head valid, head++, count-- -> IDLE. A drain is never aborted by a new request; requests wait.
- At most one entry ever matches a tag (coalescing guarantees this), so a read hit is unambiguous and returns the newest data.
- pmem_read and pmem_write are never both high.
- mem_rdata holds its last value outside RESP.
- Wrap-around: pointers wrap DEPTH-1 -> 0; full = (count==DEPTH), empty = (count==0).
- Upstream obligation: the requester deasserts or changes its request on the edge after mem_resp.

Test Plan:
1. Write line 0x1240 (data A) on an empty buffer -> mem_resp 1 cycle later, no pmem activity during the write, count=1; then idle -> pmem_write to 0x1240 with data A, count=0 after pmem_resp.
2. Write 0x2000 = B, then read 0x2010 -> mem_rdata=B one cycle after accept, pmem_read never asserted.
3. Write 0x3000 = C, then write 0x3000 = D -> count stays 1; the later drain writes D only, once.
4. With requests held continuously, fill DEPTH=4 lines (0x0000, 0x0020, 0x0040, 0x0060), then write 0x0080 -> DRAIN of 0x0000 first, then 0x0080 accepted. Tail wraps to 0; subsequent drain order is 0x0020, 0x0040, 0x0060, 0x0080.
5. Read miss 0x4000 with pmem latency 5 while buffer holds 2 lines -> pmem_read issued before any drain, mem_resp at cycle 6, data equals pmem_rdata.
6. Assert reset low during DRAIN -> pmem_write drops immediately, count=0. A read of a previously buffered line after reset goes to pmem.
